// File: rtl/mdu_div_pkg.sv
// ---------------------------------------------------------------------------
// mdu_div_pkg
// Shared control encodings for the divide unit: operation codes, FSM state
// encodings, the iteration count and small helpers for magnitude / sign
// handling of signed operands.
// ---------------------------------------------------------------------------
package mdu_div_pkg;

    // Operation codes as presented on the op port.
    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } div_state_e;

    // Index of the final restoring-division iteration (32 iterations total).
    localparam logic [5:0] LAST_ITER = 6'd31;

    localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN  = 32'h8000_0000;

    function automatic logic is_signed_op(input div_op_e o);
        return (o == OP_DIV) || (o == OP_REM);
    endfunction

    function automatic logic is_rem_op(input div_op_e o);
        return (o == OP_REM) || (o == OP_REMU);
    endfunction

    // Two's complement negation when en is set. Used both for taking the
    // magnitude of a negative operand and for restoring the result sign.
    function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic en);
        return en ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mdu_div.sv
// ---------------------------------------------------------------------------
// mdu_div
// Iterative 32-bit divider (DIV / DIVU / REM / REMU) using restoring
// division on operand magnitudes, one quotient bit per clock.
//
// Ports:
//   clk        : clock, all state updates on the rising edge
//   rstn       : asynchronous active-low reset
//   in_valid   : request present
//   in_ready   : unit can accept a request (registered, high only in IDLE)
//   op         : 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   a, b       : dividend, divisor (latched on accept)
//   kill       : abort any operation in flight
//   out_valid  : result holds a completed value
//   out_ready  : consumer takes the result
//   result     : quotient or remainder, zero whenever out_valid is low
//   busy       : high in any state other than IDLE
// ---------------------------------------------------------------------------
module mdu_div
    import mdu_div_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        kill,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        busy
);

    div_state_e  state;
    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] dvs_q;
    logic [5:0]  cnt_q;
    logic        rem_op_q;
    logic        quo_neg_q;
    logic        rem_neg_q;

    div_op_e     op_code;
    logic        accept;
    logic        sgn_req;
    logic        rem_req;
    logic        div_zero;
    logic        overflow;
    logic [31:0] direct_res;

    logic [32:0] shifted;
    logic [32:0] diff;
    logic        q_bit;
    logic [31:0] rem_next;
    logic [31:0] quo_next;
    logic [31:0] final_res;

    assign op_code  = div_op_e'(op);
    assign accept   = in_valid && in_ready && !kill;
    assign sgn_req  = is_signed_op(op_code);
    assign rem_req  = is_rem_op(op_code);
    assign div_zero = (b == 32'd0);
    assign overflow = sgn_req && (a == INT_MIN) && (b == ALL_ONES);

    // Results that bypass the iteration: divide-by-zero and signed overflow.
    assign direct_res = div_zero ? (rem_req ? a : ALL_ONES)
                                 : (rem_req ? 32'd0 : INT_MIN);

    // One restoring step. The dividend is shifted out of the top of the
    // quotient register into the partial remainder. Because the partial
    // remainder is always below the divisor, a 33-bit difference suffices:
    // bit 32 is set exactly when the trial subtraction would go negative.
    assign shifted  = {rem_q, quo_q[31]};
    assign diff     = shifted - {1'b0, dvs_q};
    assign q_bit    = ~diff[32];
    assign rem_next = q_bit ? diff[31:0] : shifted[31:0];
    assign quo_next = {quo_q[30:0], q_bit};

    assign final_res = rem_op_q ? cond_neg(rem_next, rem_neg_q)
                                : cond_neg(quo_next, quo_neg_q);

    // Controller and datapath. in_ready and busy are registered from the
    // next state, so in_ready comes up on the first edge after reset and is
    // low in the cycle that DONE hands off to IDLE.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            rem_op_q  <= 1'b0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            result    <= '0;
        end else if (kill) begin
            state     <= ST_IDLE;
            cnt_q     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            result    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        rem_op_q  <= rem_req;
                        quo_neg_q <= sgn_req && (a[31] ^ b[31]);
                        rem_neg_q <= sgn_req && a[31];
                        rem_q     <= '0;
                        quo_q     <= cond_neg(a, sgn_req && a[31]);
                        dvs_q     <= cond_neg(b, sgn_req && b[31]);
                        cnt_q     <= '0;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                        if (div_zero || overflow) begin
                            state     <= ST_DONE;
                            out_valid <= 1'b1;
                            result    <= direct_res;
                        end else begin
                            state <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    rem_q <= rem_next;
                    quo_q <= quo_next;
                    cnt_q <= cnt_q + 6'd1;
                    if (cnt_q == LAST_ITER) begin
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                        result    <= final_res;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        result    <= '0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    result    <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/mdu_div.md
MDU_DIV -- requirements
Module: mdu_div

Interface
REQ-001 SHALL have no parameters; all datapaths are fixed at 32 bits.
REQ-002 SHALL have `clk`, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have `rstn`, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have `in_valid`, input, 1: request present.
REQ-005 SHALL have `in_ready`, output, 1: unit can accept a request.
REQ-006 SHALL have `op`, input, 2: 00 = DIV, 01 = DIVU, 10 = REM, 11 = REMU.
REQ-007 SHALL have `a`, input, 32: dividend.
REQ-008 SHALL have `b`, input, 32: divisor.
REQ-009 SHALL have `kill`, input, 1: abort any operation in flight (pipeline flush).
REQ-010 SHALL have `out_valid`, output, 1: `result` holds a completed value.
REQ-011 SHALL have `out_ready`, input, 1: consumer takes the result.
REQ-012 SHALL have `result`, output, 32: quotient or remainder, as selected by `op`.
REQ-013 SHALL have `busy`, output, 1: high in any state other than IDLE.

Function
REQ-014 SHALL implement states IDLE, CALC and DONE.
REQ-015 SHALL drive `in_ready` = 1 only in IDLE; a request is accepted on a rising edge with `in_valid` && `in_ready`, latching `op`, `a` and `b`.
REQ-016 SHALL move IDLE -> CALC on accept for a normal request, then iterate restoring division on magnitudes, one quotient bit per cycle, for exactly 32 CALC cycles.
REQ-017 SHALL move CALC -> DONE after the 32nd iteration; `out_valid` rises 33 cycles after the accept edge.
REQ-018 SHALL, for divisor = 0, move IDLE -> DONE directly; `out_valid` rises 1 cycle after accept; quotient = 0xFFFFFFFF and remainder = `a`, for both signed and unsigned ops.
REQ-019 SHALL, for DIV/REM with `a` = 0x80000000 and `b` = 0xFFFFFFFF, move directly to DONE with quotient = 0x80000000 and remainder = 0.
REQ-020 SHALL use sign rules for DIV/REM: operands converted to magnitudes; quotient negated when the operand signs differ; remainder takes the sign of the dividend; the result truncates toward zero.
REQ-021 SHALL hold `out_valid` = 1 and `result` stable in DONE until `out_ready` = 1, then go to IDLE; no request is accepted in that same cycle.
REQ-022 SHALL, on `kill` = 1 in any state, go to IDLE on the next edge with `out_valid` = 0; `kill` overrides `out_ready` and accept.
REQ-023 SHALL drive `result` = 0 whenever `out_valid` = 0.
REQ-024 SHALL ignore changes on `a`, `b` and `op` after accept.

Reset
REQ-025 SHALL, on `rstn` low, immediately force state = IDLE, `out_valid` = 0, `busy` = 0, `result` = 0, and clear all internal registers, including when asserted mid-CALC or in DONE.
REQ-026 SHALL drive `in_ready` = 1 on the first edge after `rstn` deasserts.

Structure
REQ-027 SHALL take the DIV/DIVU/REM/REMU op codes and the state encodings from the team's shared control-encoding definitions file.
REQ-028 SHALL be a single module with no sub-module; the iteration datapath is a 32-bit remainder register, a 32-bit quotient shift register, a 6-bit iteration counter and a 33-bit subtractor.

Verification
REQ-029 SHALL cover DIVU 100/7 -> 14, with `out_valid` exactly 33 cycles after accept; REMU 100/7 -> 2.
REQ-030 SHALL cover DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD and REM 0xFFFFFFF9 / 2 -> 0xFFFFFFFF; DIV 7 / 0xFFFFFFFE -> 0xFFFFFFFD.
REQ-031 SHALL cover divide-by-zero: DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, each with 1-cycle latency; overflow DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
REQ-032 SHALL cover backpressure: `out_ready` held low for 5 cycles in DONE -> `result` stable, `in_ready` = 0; `out_ready` high -> IDLE the next cycle.
REQ-033 SHALL cover `kill` at CALC cycle 10 -> IDLE next edge, `out_valid` never rises; the following DIVU 9/3 -> 3 is correct.
REQ-034 SHALL cover `rstn` low mid-CALC -> all outputs 0 immediately and `in_ready` = 1 after release.
